// File: rtl/ff256_mult_pkg.sv
// Shared constants and state encoding for the GF(256) multiplier
// Wishbone master and its wait timer.
package ff256_mult_pkg;

  localparam logic [1:0] OPERAND_ADDR = 2'b00;
  localparam logic [1:0] RESULT_ADDR  = 2'b11;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_GAP,
    ST_RD,
    ST_RESP
  } state_e;

endpackage

// File: rtl/ff256_mult_wb_timer.sv
// Clearable saturating wait counter; expire flags the last
// allowed cycle of a bus access.
module ff256_mult_wb_timer
  import ff256_mult_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] MAX = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == MAX);

endmodule

// File: rtl/ff256_mult_wb_master.sv
// Wishbone master: writes an operand pair to the GF(256) multiplier
// slave, reads the product back, and hands it to the consumer.
module ff256_mult_wb_master
  import ff256_mult_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid_i,
  input  logic [7:0]            op_f_i,
  input  logic [7:0]            op_p_i,
  output logic                  op_ready_o,
  output logic                  res_valid_o,
  output logic [7:0]            res_data_o,
  output logic                  res_err_o,
  input  logic                  res_ready_i,
  output logic [BUS_WIDTH-1:0]  adr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic [BE_WIDTH-1:0]   sel_o,
  input  logic                  ack_i
);

  state_e state_q, state_d;

  logic [BUS_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic                  res_valid_q, res_valid_d;
  logic [7:0]            res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;

  logic in_access;
  logic tmo_expired;
  logic unused_data;

  assign in_access = (state_q == ST_WR) || (state_q == ST_RD);

  ff256_mult_wb_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!in_access),
    .inc_i    (in_access && !ack_i),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    data_d     = data_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid_i) begin
          state_d      = ST_WR;
          adr_d        = BUS_WIDTH'(OPERAND_ADDR);
          data_d       = '0;
          data_d[7:0]  = op_f_i;
          data_d[15:8] = op_p_i;
        end
      end
      ST_WR: begin
        if (ack_i) begin
          state_d = ST_GAP;
        end else if (tmo_expired) begin
          state_d    = ST_RESP;
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_RD;
        adr_d   = BUS_WIDTH'(RESULT_ADDR);
      end
      ST_RD: begin
        if (ack_i) begin
          state_d    = ST_RESP;
          res_data_d = data_i[7:0];
          res_err_d  = 1'b0;
        end else if (tmo_expired) begin
          state_d    = ST_RESP;
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
      end
      ST_RESP: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // bus/result strobes follow the state being entered
    cyc_d       = (state_d == ST_WR) || (state_d == ST_RD);
    we_d        = (state_d == ST_WR);
    res_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      data_q      <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign op_ready_o  = (state_q == ST_IDLE);
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;
  assign adr_o       = adr_q;
  assign data_o      = data_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign sel_o       = '1;

  assign unused_data = ^data_i[DATA_WIDTH-1:8];

endmodule

// File: tb/tb_ff256_mult_wb_master.sv
// Bench for ff256_mult_wb_master: behavioural multiplier slave with
// programmable ack delay / ack blocking, checked against a GF(256) model.
module tb_ff256_mult_wb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid_i;
  logic [7:0]  op_f_i;
  logic [7:0]  op_p_i;
  logic        op_ready_o;
  logic        res_valid_o;
  logic [7:0]  res_data_o;
  logic        res_err_o;
  logic        res_ready_i;
  logic [1:0]  adr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [3:0]  sel_o;
  logic        ack_i;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ff256_mult_wb_master dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid_i (op_valid_i),
    .op_f_i     (op_f_i),
    .op_p_i     (op_p_i),
    .op_ready_o (op_ready_o),
    .res_valid_o(res_valid_o),
    .res_data_o (res_data_o),
    .res_err_o  (res_err_o),
    .res_ready_i(res_ready_i),
    .adr_o      (adr_o),
    .data_o     (data_o),
    .data_i     (data_i),
    .we_o       (we_o),
    .stb_o      (stb_o),
    .cyc_o      (cyc_o),
    .sel_o      (sel_o),
    .ack_i      (ack_i)
  );

  // carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
    return prod[7:0];
  endfunction

  // slave model
  int          ack_dly = 0;
  int          blk = 0;
  int          wait_cnt = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          glitch = 0;
  logic [15:0] s_op = '0;
  logic [31:0] last_wr_data = '0;
  logic [1:0]  last_wr_adr = '0;
  logic [1:0]  last_rd_adr = '0;
  logic        prev_cyc = 1'b0;
  logic        prev_ack = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_i    <= 1'b0;
      wait_cnt <= 0;
      prev_cyc <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      prev_cyc <= cyc_o;
      prev_ack <= ack_i;
      if (prev_cyc && !cyc_o && !prev_ack) glitch <= glitch + 1;
      ack_i <= 1'b0;
      if (cyc_o && stb_o && !ack_i) begin
        if ((blk == 1 && we_o) || (blk == 2 && !we_o)) begin
          wait_cnt <= 0;
        end else if (wait_cnt >= ack_dly) begin
          ack_i    <= 1'b1;
          wait_cnt <= 0;
          if (we_o) begin
            n_wr         <= n_wr + 1;
            last_wr_data <= data_o;
            last_wr_adr  <= adr_o;
            s_op         <= data_o[15:0];
          end else begin
            n_rd        <= n_rd + 1;
            last_rd_adr <= adr_o;
            data_i      <= {24'hA5C3E1, gf_mul(s_op[7:0], s_op[15:8])};
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  logic [7:0] res_q[$];

  always @(posedge clk)
    if (reset && res_valid_o && res_ready_i) res_q.push_back(res_data_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] f, input logic [7:0] p,
                        input int hold, input string tag);
    logic       exp_err;
    logic [7:0] exp_d;
    int         lat;
    int         wr0;
    int         rd0;
    exp_err = (blk != 0);
    exp_d   = exp_err ? 8'h00 : gf_mul(f, p);
    wr0 = n_wr;
    rd0 = n_rd;
    lat = 0;
    while (!op_ready_o && lat < 50) begin step(); lat++; end
    chk({tag, "_rdy"}, 32'(op_ready_o), 1);
    op_valid_i = 1'b1;
    op_f_i = f;
    op_p_i = p;
    step();
    op_valid_i = 1'b0;
    lat = 0;
    while (!res_valid_o && lat < 200) begin step(); lat++; end
    chk({tag, "_valid"}, 32'(res_valid_o), 1);
    if (ack_dly == 0 && blk == 0) chk({tag, "_lat"}, lat, 5);
    chk({tag, "_data"}, 32'(res_data_o), 32'(exp_d));
    chk({tag, "_err"}, 32'(res_err_o), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold"}, {res_valid_o, op_ready_o, res_data_o}, {2'b10, exp_d});
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    chk({tag, "_drop"}, 32'(res_valid_o), 0);
    chk({tag, "_nwr"}, n_wr - wr0, (blk == 1) ? 0 : 1);
    chk({tag, "_nrd"}, n_rd - rd0, (blk == 0) ? 1 : 0);
  endtask

  initial begin
    int         cnt;
    int         g0;
    int         wr0;
    int         rd0;
    logic [7:0] a;
    logic [7:0] b;

    reset       = 1'b0;
    op_valid_i  = 1'b0;
    op_f_i      = '0;
    op_p_i      = '0;
    res_ready_i = 1'b0;
    data_i      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", {cyc_o, stb_o, we_o, adr_o}, 0);
    chk("rst_wdata", data_o, 0);
    chk("rst_res", {res_valid_o, res_err_o, res_data_o}, 0);
    chk("rst_sel", 32'(sel_o), 32'hF);
    reset = 1'b1;
    chk("rst_rdy", 32'(op_ready_o), 1);

    run_op(8'h53, 8'hCA, 0, "basic");
    chk("basic_wdata", last_wr_data, 32'h0000CA53);
    chk("basic_wadr", 32'(last_wr_adr), 0);
    chk("basic_radr", 32'(last_rd_adr), 3);

    for (int i = 0; i < 6; i++) begin
      ack_dly = $urandom_range(0, 3);
      run_op(8'($urandom), 8'($urandom), $urandom_range(0, 2), "rand");
    end

    ack_dly = 5;
    g0 = glitch;
    run_op(8'($urandom), 8'($urandom), 0, "slow");
    chk("slow_steady", glitch - g0, 0);

    ack_dly = 0;
    run_op(8'($urandom), 8'($urandom), 10, "hold");

    blk = 1;
    cnt = 0;
    while (!op_ready_o && cnt < 50) begin step(); cnt++; end
    op_valid_i = 1'b1;
    op_f_i = 8'h11;
    op_p_i = 8'h22;
    step();
    op_valid_i = 1'b0;
    cnt = 0;
    while (cyc_o && cnt < 100) begin step(); cnt++; end
    chk("tmo_len", cnt, 16);
    chk("tmo_res", {res_valid_o, res_err_o, res_data_o}, {2'b11, 8'h00});
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    blk = 0;
    run_op(8'h07, 8'h09, 0, "after_tmo");

    blk = 2;
    run_op(8'h35, 8'h8E, 0, "tmo_rd");
    blk = 0;

    ack_dly = 5;
    op_valid_i = 1'b1;
    op_f_i = 8'h13;
    op_p_i = 8'h57;
    step();
    op_valid_i = 1'b0;
    cnt = 0;
    while (!(cyc_o && !we_o) && cnt < 100) begin step(); cnt++; end
    chk("rrd_in_rd", 32'(cyc_o && !we_o), 1);
    step();
    reset = 1'b0;
    #1;
    chk("rrd_bus", {cyc_o, stb_o, we_o, adr_o}, 0);
    chk("rrd_wdata", data_o, 0);
    chk("rrd_res", {res_valid_o, res_err_o, res_data_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rrd_rdy", 32'(op_ready_o), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid_o) cnt++;
      step();
    end
    chk("rrd_noresult", cnt, 0);
    ack_dly = 0;
    run_op(8'h02, 8'h02, 0, "rrd_next");
    chk("rrd_next_val", 32'(gf_mul(8'h02, 8'h02)), 32'h04);

    a = 8'($urandom);
    b = 8'($urandom);
    res_q.delete();
    wr0 = n_wr;
    rd0 = n_rd;
    res_ready_i = 1'b1;
    op_valid_i = 1'b1;
    op_f_i = a;
    op_p_i = b;
    step();
    op_f_i = b;
    op_p_i = a ^ 8'h5A;
    cnt = 0;
    while (!op_ready_o && cnt < 50) begin step(); cnt++; end
    step();
    op_valid_i = 1'b0;
    cnt = 0;
    while (res_q.size() < 2 && cnt < 100) begin step(); cnt++; end
    repeat (5) step();
    chk("b2b_count", res_q.size(), 2);
    if (res_q.size() == 2) begin
      chk("b2b_r0", 32'(res_q[0]), 32'(gf_mul(a, b)));
      chk("b2b_r1", 32'(res_q[1]), 32'(gf_mul(b, a ^ 8'h5A)));
    end
    chk("b2b_nwr", n_wr - wr0, 2);
    chk("b2b_nrd", n_rd - rd0, 2);
    res_ready_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ff256_mult_wb_master.md
FF256_MULT_WB_MASTER -- requirements
Module: ff256_mult_wb_master

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have parameter BE_WIDTH, default 4, byte-select width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16, maximum cycles waited for ack_i per bus access.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 op_valid_i  input  1  operand pair valid.
REQ-008 op_f_i  input  8  GF(256) operand f.
REQ-009 op_p_i  input  8  GF(256) operand p.
REQ-010 op_ready_o  output  1  operand pair accepted when op_valid_i and op_ready_o are both high.
REQ-011 res_valid_o  output  1  product valid.
REQ-012 res_data_o  output  8  GF(256) product.
REQ-013 res_err_o  output  1  transaction aborted by timeout; qualified by res_valid_o.
REQ-014 res_ready_i  input  1  consumer accepts result.
REQ-015 adr_o  output  BUS_WIDTH  Wishbone address.
REQ-016 data_o  output  DATA_WIDTH  Wishbone write data.
REQ-017 data_i  input  DATA_WIDTH  Wishbone read data.
REQ-018 we_o, stb_o, cyc_o  output  1 each  Wishbone write-enable, strobe, cycle.
REQ-019 sel_o  output  BE_WIDTH  byte select; constant all-ones.
REQ-020 ack_i  input  1  Wishbone acknowledge from the multiplier slave.

Function
REQ-021 SHALL implement states IDLE, WR, GAP, RD, RESP.
REQ-022 IDLE: op_ready_o=1; on handshake, latch f and p, go to WR.
REQ-023 WR: cyc_o=stb_o=we_o=1, adr_o=OPERAND_ADDR, data_o={zeros, p, f} with f at [7:0] and p at [15:8]; on ack_i go to GAP.
REQ-024 GAP: one cycle with cyc_o=stb_o=we_o=0, then go to RD.
REQ-025 RD: cyc_o=stb_o=1, we_o=0, adr_o=RESULT_ADDR; on ack_i capture data_i[7:0] into res_data_o, res_err_o=0, go to RESP.
REQ-026 RESP: res_valid_o=1, with res_data_o/res_err_o held stable; on res_ready_i go to IDLE.
REQ-027 Wait counter SHALL clear on entry to WR and to RD, and increment each cycle without ack_i.
REQ-028 When the counter reaches TIMEOUT_CYC-1 without ack_i:
- drop cyc_o/stb_o next cycle;
- set res_err_o=1, res_data_o=8'h00;
- go to RESP.
REQ-029 ack_i SHALL be ignored outside WR and RD; ack_i on the timeout cycle counts as success.
REQ-030 Per transaction, without stalls: WR ack at earliest 1 cycle after handshake; res_valid_o at earliest 1 cycle after RD ack; minimum handshake-to-res_valid_o with single-cycle acks is 5 cycles.
REQ-031 op_ready_o SHALL be 0 in every state except IDLE; one transaction in flight at most.
REQ-032 Outputs SHALL be registered, with no combinational path from ack_i or res_ready_i to any Wishbone output.

Reset
REQ-033 Asserted reset SHALL force:
- IDLE;
- cyc_o=stb_o=we_o=0, adr_o=0, data_o=0;
- res_valid_o=0, res_data_o=0, res_err_o=0;
- counter=0.
REQ-034 Reset mid-transaction SHALL abandon it with no result; after release, op_ready_o=1 on the first clock.

Structure
REQ-035 Shared package ff256_mult_pkg SHALL hold:
- OPERAND_ADDR=2'b00 and RESULT_ADDR=2'b11 (slave config/result address);
- state encoding;
- default TIMEOUT_CYC.
REQ-036 A sub-module ff256_mult_wb_timer (clearable saturating counter with expire flag) SHALL implement the wait counter.

Verification
REQ-037 f=8'h53, p=8'hCA, slave acks in 1 cycle -> write data 32'h0000CA53 to adr 0, then read of adr 3; res_data_o=8'h01, res_err_o=0.
REQ-038 Slave ack delayed 5 cycles on each access -> cyc_o/stb_o held steady until ack, then correct product; no extra access.
REQ-039 Slave never acks in WR -> after 16 cycles cyc_o drops; res_valid_o=1, res_err_o=1, res_data_o=0; next op accepted.
REQ-040 res_ready_i held low 10 cycles -> res_valid_o/res_data_o stable; op_ready_o=0 throughout.
REQ-041 reset pulsed low during RD -> all outputs zero immediately; no result emitted; new op f=8'h02, p=8'h02 yields 8'h04.
REQ-042 Back-to-back ops with res_ready_i=1 constant -> exactly two write/read pairs, results in order.
